// File: rtl/ps2_rx_fifo_pkg.sv
// Shared PS/2 frame constants and scan codes, used by the receiver and the keyboard decoder.
package ps2_rx_fifo_pkg;

    typedef logic [7:0] scan_code_t;

    localparam int         PS2_FRAME_BITS = 11;
    localparam logic       PS2_START      = 1'b0;
    localparam logic       PS2_STOP       = 1'b1;
    localparam scan_code_t PS2_BREAK      = 8'hF0;
    localparam scan_code_t PS2_EXTEND     = 8'hE0;

    // The shift register holds {parity, data[7:0], start}; the stop bit arrives live on the last fall.
    function automatic logic frame_good(input logic [9:0] shift, input logic stop_bit);
        return (shift[0] == PS2_START) && (stop_bit == PS2_STOP) && ((^shift[9:1]) == 1'b1);
    endfunction

endpackage

// File: rtl/ps2_byte_fifo.sv
// Synchronous byte FIFO with wrap-bit pointers; a push into a full FIFO is taken only alongside a pop.
module ps2_byte_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push_i,
    input  logic [7:0] wdata_i,
    input  logic       pop_i,
    output logic [7:0] rdata_o,
    output logic       full_o,
    output logic       empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem_q [DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: synchronise, deserialise, check frames, buffer scan codes.
module ps2_rx_fifo
    import ps2_rx_fifo_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       nextdata_n,
    output logic [7:0] data,
    output logic       ready,
    output logic       overflow,
    output logic       frame_err
);
    localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]    LAST_BIT = 4'(PS2_FRAME_BITS - 1);

    logic [2:0]    clk_sync_q;
    logic [1:0]    dat_sync_q;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [9:0]    shift_q, shift_d;
    logic [TW-1:0] tmo_q, tmo_d;
    scan_code_t    push_byte_q, push_byte_d;
    logic          push_q, push_d;
    logic          frame_err_q, frame_err_d;
    logic          overflow_q, overflow_d;
    logic          fall, bit_in, full, empty, pop_ok, drop;

    assign fall   = clk_sync_q[2] & ~clk_sync_q[1];
    assign bit_in = dat_sync_q[1];

    // Timeout only runs mid-frame; a fall always reloads it.
    always_comb begin
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        tmo_d       = tmo_q;
        push_d      = 1'b0;
        push_byte_d = push_byte_q;
        frame_err_d = 1'b0;
        if (fall) begin
            tmo_d = TMO_LOAD;
            if (bit_cnt_q == LAST_BIT) begin
                bit_cnt_d = '0;
                if (frame_good(shift_q, bit_in)) begin
                    push_d      = 1'b1;
                    push_byte_d = shift_q[8:1];
                end else begin
                    frame_err_d = 1'b1;
                end
            end else begin
                shift_d   = {bit_in, shift_q[9:1]};
                bit_cnt_d = bit_cnt_q + 1'b1;
            end
        end else if (bit_cnt_q != '0) begin
            if (tmo_q == '0) begin
                bit_cnt_d   = '0;
                frame_err_d = 1'b1;
            end else begin
                tmo_d = tmo_q - 1'b1;
            end
        end
    end

    assign ready  = ~empty;
    assign pop_ok = ~nextdata_n & ready;
    assign drop   = push_q & full & ~pop_ok;

    always_comb begin
        overflow_d = overflow_q;
        if (drop)        overflow_d = 1'b1;
        else if (pop_ok) overflow_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_sync_q  <= '1;
            dat_sync_q  <= '1;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            tmo_q       <= TMO_LOAD;
            push_q      <= 1'b0;
            push_byte_q <= '0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            clk_sync_q  <= {clk_sync_q[1:0], ps2_clk};
            dat_sync_q  <= {dat_sync_q[0], ps2_data};
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            tmo_q       <= tmo_d;
            push_q      <= push_d;
            push_byte_q <= push_byte_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
        end
    end

    assign frame_err = frame_err_q;
    assign overflow  = overflow_q;

    ps2_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .push_i  (push_q),
        .wdata_i (push_byte_q),
        .pop_i   (~nextdata_n),
        .rdata_o (data),
        .full_o  (full),
        .empty_o (empty)
    );

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: good/bad frames, overflow, full push+pop, timeout, mid-frame reset.
module tb_ps2_rx_fifo;
    import ps2_rx_fifo_pkg::*;

    localparam int HP  = 20;
    localparam int TMO = 500;

    logic       clk = 1'b0;
    logic       rst, ps2_clk, ps2_data, nextdata_n;
    logic [7:0] data;
    logic       ready, overflow, frame_err;

    int n_checks   = 0;
    int n_fail     = 0;
    int err_cycles = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (frame_err === 1'b1) err_cycles++;

    ps2_rx_fifo #(.FIFO_DEPTH(8), .TIMEOUT_CYCLES(TMO)) dut (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .nextdata_n (nextdata_n),
        .data       (data),
        .ready      (ready),
        .overflow   (overflow),
        .frame_err  (frame_err)
    );

    function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic bad_par);
        logic p;
        p = ~(^b) ^ bad_par;
        return {1'b1, p, b, 1'b0};
    endfunction

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = f[i];
            wait_clks(HP / 2);
            ps2_clk = 1'b0;
            wait_clks(HP);
            ps2_clk = 1'b1;
            wait_clks(HP / 2);
        end
    endtask

    task automatic send_frame(input logic [7:0] b);
        send_bits(mk_frame(b, 1'b0), 11);
        wait_clks(4);
    endtask

    task automatic pop_one();
        @(negedge clk) nextdata_n = 1'b0;
        @(negedge clk) nextdata_n = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1; nextdata_n = 1'b1;
        wait_clks(3);
        n_checks++; if (data !== 8'h00)    begin n_fail++; $display("FAIL reset_data got %h exp 00", data); end
        n_checks++; if (ready !== 1'b0)    begin n_fail++; $display("FAIL reset_ready got %b exp 0", ready); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %b exp 0", overflow); end
        n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err got %b exp 0", frame_err); end
        rst = 1'b1;
        wait_clks(3);
    endtask

    task automatic test_good_frame();
        logic [10:0] f;
        int lat;
        int e0;
        e0 = err_cycles;
        f  = mk_frame(8'h1C, 1'b0);
        send_bits(f, 10);
        ps2_data = f[10];
        wait_clks(HP / 2);
        ps2_clk = 1'b0;
        lat = 0;
        while (ready !== 1'b1 && lat < 12) begin
            @(posedge clk); #1;
            lat++;
        end
        n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL good_latency got %0d exp 4", lat); end
        wait_clks(HP);
        ps2_clk = 1'b1;
        wait_clks(HP / 2);
        n_checks++; if (data !== 8'h1C) begin n_fail++; $display("FAIL good_data got %h exp 1c", data); end
        pop_one();
        n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL good_pop_ready got %b exp 0", ready); end
        n_checks++; if (err_cycles - e0 !== 0) begin n_fail++; $display("FAIL good_no_err got %0d exp 0", err_cycles - e0); end
    endtask

    task automatic test_bad_parity();
        int e0;
        e0 = err_cycles;
        send_bits(mk_frame(8'h1C, 1'b1), 11);
        wait_clks(4);
        n_checks++; if (err_cycles - e0 !== 1) begin n_fail++; $display("FAIL badpar_err_cycles got %0d exp 1", err_cycles - e0); end
        n_checks++; if (ready !== 1'b0)    begin n_fail++; $display("FAIL badpar_ready got %b exp 0", ready); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL badpar_overflow got %b exp 0", overflow); end
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 9; i++) send_frame(8'(i));
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set got %b exp 1", overflow); end
        n_checks++; if (ready !== 1'b1)    begin n_fail++; $display("FAIL ovf_ready got %b exp 1", ready); end
        for (int i = 1; i <= 8; i++) begin
            n_checks++; if (data !== 8'(i)) begin n_fail++; $display("FAIL ovf_pop_data got %h exp %h", data, 8'(i)); end
            pop_one();
            if (i == 1) begin
                n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got %b exp 0", overflow); end
            end
        end
        n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL ovf_drained_ready got %b exp 0", ready); end
    endtask

    task automatic test_full_push_pop();
        logic [10:0] f;
        for (int i = 0; i < 8; i++) send_frame(8'(8'h30 + i));
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL full_pre_overflow got %b exp 0", overflow); end
        f = mk_frame(8'h55, 1'b0);
        send_bits(f, 10);
        ps2_data = f[10];
        wait_clks(HP / 2);
        ps2_clk = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) nextdata_n = 1'b0;
        @(negedge clk) nextdata_n = 1'b1;
        wait_clks(HP);
        ps2_clk = 1'b1;
        wait_clks(HP / 2);
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL full_pushpop_overflow got %b exp 0", overflow); end
        n_checks++; if (ready !== 1'b1)    begin n_fail++; $display("FAIL full_pushpop_ready got %b exp 1", ready); end
        for (int i = 1; i <= 8; i++) begin
            logic [7:0] exp_b;
            exp_b = (i == 8) ? 8'h55 : 8'(8'h30 + i);
            n_checks++; if (data !== exp_b) begin n_fail++; $display("FAIL full_pop_data got %h exp %h", data, exp_b); end
            pop_one();
        end
        n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL full_drained_ready got %b exp 0", ready); end
    endtask

    task automatic test_timeout();
        int e0;
        e0 = err_cycles;
        send_bits(mk_frame(8'hAA, 1'b0), 5);
        wait_clks(TMO + 10);
        n_checks++; if (err_cycles - e0 !== 1) begin n_fail++; $display("FAIL tmo_err_cycles got %0d exp 1", err_cycles - e0); end
        n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL tmo_ready got %b exp 0", ready); end
        send_frame(PS2_BREAK);
        n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL tmo_next_ready got %b exp 1", ready); end
        n_checks++; if (data !== 8'hF0) begin n_fail++; $display("FAIL tmo_next_data got %h exp f0", data); end
        n_checks++; if (err_cycles - e0 !== 1) begin n_fail++; $display("FAIL tmo_next_no_err got %0d exp 1", err_cycles - e0); end
        pop_one();
    endtask

    task automatic test_reset_midframe();
        int e0;
        e0 = err_cycles;
        send_bits(mk_frame(8'h5A, 1'b0), 6);
        rst = 1'b0;
        wait_clks(3);
        rst = 1'b1;
        wait_clks(3);
        send_frame(8'h29);
        n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready got %b exp 1", ready); end
        n_checks++; if (data !== 8'h29) begin n_fail++; $display("FAIL rstmid_data got %h exp 29", data); end
        pop_one();
        n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_single got %b exp 0", ready); end
        n_checks++; if (err_cycles - e0 !== 0) begin n_fail++; $display("FAIL rstmid_no_err got %0d exp 0", err_cycles - e0); end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_parity();
        test_overflow();
        test_full_push_pop();
        test_timeout();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #900us;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

endmodule
